// File: rtl/mem_wb_pipeline.sv
// -----------------------------------------------------------------------------
// mem_wb_pipeline
//
// EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core, plus the
// data-memory access FSM of the MEM stage. It also produces the load-use and
// memory-wait stalls, the forwarding sources for data_forwarding and the
// register-file write port.
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   defined   : a data-memory access that waits TIMEOUT_CYCLES stall cycles is
//               abandoned, a load writes 0 and the sticky dmem_err flag is set.
//   undefined : WAIT lasts until dmem_ready, dmem_err is tied to 0.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ex_valid, ex_rd, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg,
//   ex_alu_result, ex_store_data  EX-stage instruction fields
//   id_rs1, id_rs2                ID-stage sources for the load-use check
//   dmem_req/we/addr/wdata        data-memory request (outputs)
//   dmem_ready, dmem_rdata        data-memory response (inputs)
//   mem_rd, mem_regWrite,
//   mem_fwd_data                  EX/MEM forwarding source
//   wb_rd, wb_regWrite, wb_data   MEM/WB forwarding source
//   rf_we, rf_waddr, rf_wdata     register-file write port
//   mem_stall, ld_use_stall       pipeline stall requests
//   stall_cycles                  saturating count of mem_stall cycles
//   dmem_err                      sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_wb_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_SIZE       = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [REG_SIZE-1:0]   ex_rd,
    input  logic                  ex_regWrite,
    input  logic                  ex_memRead,
    input  logic                  ex_memWrite,
    input  logic                  ex_memToReg,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [REG_SIZE-1:0]   id_rs1,
    input  logic [REG_SIZE-1:0]   id_rs2,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [REG_SIZE-1:0]   mem_rd,
    output logic                  mem_regWrite,
    output logic [DATA_WIDTH-1:0] mem_fwd_data,
    output logic [REG_SIZE-1:0]   wb_rd,
    output logic                  wb_regWrite,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  rf_we,
    output logic [REG_SIZE-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  mem_stall,
    output logic                  ld_use_stall,
    output logic [31:0]           stall_cycles,
    output logic                  dmem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // EX/MEM register
    logic                  r_mem_valid;
    logic [REG_SIZE-1:0]   r_mem_rd;
    logic                  r_mem_regWrite;
    logic                  r_mem_memRead;
    logic                  r_mem_memWrite;
    logic                  r_mem_memToReg;
    logic [DATA_WIDTH-1:0] r_mem_alu;
    logic [DATA_WIDTH-1:0] r_mem_store;

    // MEM/WB register
    logic                  r_wb_valid;
    logic [REG_SIZE-1:0]   r_wb_rd;
    logic                  r_wb_regWrite;
    logic [DATA_WIDTH-1:0] r_wb_data;

    logic [31:0]           r_stall_cycles;
    logic                  w_mem_access;
    logic                  w_timeout;
    logic                  w_mem_stall;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_mem_access = r_mem_valid & (r_mem_memRead | r_mem_memWrite);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_dmem_err;

    // The counter is zero on the first WAIT cycle because it is held clear in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_dmem_err <= 1'b0;
        end else begin
            if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_dmem_err <= 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) & (r_wait_cnt == CNT_LAST) & ~dmem_ready;
    assign dmem_err  = r_dmem_err;
`else
    assign w_timeout = 1'b0;
    assign dmem_err  = 1'b0;
`endif

    // An abandoned load writes zero instead of whatever is on the read bus.
    assign w_load_data = w_timeout ? '0 : dmem_rdata;
    assign w_mem_stall = w_mem_access & ~dmem_ready & ~w_timeout;

    // Access FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        dmem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                dmem_req = w_mem_access;
                if (w_mem_access && !dmem_ready)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready || w_timeout)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // EX -> MEM boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regWrite <= 1'b0;
            r_mem_memRead  <= 1'b0;
            r_mem_memWrite <= 1'b0;
            r_mem_memToReg <= 1'b0;
            r_mem_alu      <= '0;
            r_mem_store    <= '0;
        end else if (!w_mem_stall) begin
            r_mem_valid    <= ex_valid;
            r_mem_rd       <= ex_rd;
            // x0 is never a forwarding source nor a write target
            r_mem_regWrite <= ex_regWrite & (ex_rd != '0);
            r_mem_memRead  <= ex_memRead;
            r_mem_memWrite <= ex_memWrite;
            r_mem_memToReg <= ex_memToReg;
            r_mem_alu      <= ex_alu_result;
            r_mem_store    <= ex_store_data;
        end
    end

    // MEM -> WB boundary; a stalled MEM stage sends a bubble downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_regWrite <= 1'b0;
            r_wb_data     <= '0;
        end else if (w_mem_stall) begin
            r_wb_valid    <= 1'b0;
        end else begin
            r_wb_valid    <= r_mem_valid;
            r_wb_rd       <= r_mem_rd;
            r_wb_regWrite <= r_mem_regWrite;
            r_wb_data     <= r_mem_memToReg ? w_load_data : r_mem_alu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_mem_stall && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign dmem_we      = r_mem_memWrite;
    assign dmem_addr    = r_mem_alu;
    assign dmem_wdata   = r_mem_store;

    assign mem_rd       = r_mem_rd;
    assign mem_regWrite = r_mem_valid & r_mem_regWrite;
    assign mem_fwd_data = r_mem_alu;

    assign wb_rd        = r_wb_rd;
    assign wb_regWrite  = r_wb_valid & r_wb_regWrite;
    assign wb_data      = r_wb_data;

    assign rf_we        = wb_regWrite;
    assign rf_waddr     = r_wb_rd;
    assign rf_wdata     = r_wb_data;

    assign mem_stall    = w_mem_stall;
    assign stall_cycles = r_stall_cycles;

    // Load-use looks only at EX/ID; it is independent of the MEM-stage wait.
    assign ld_use_stall = ~rst & ex_valid & ex_memRead & (ex_rd != '0) &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: doc/mem_wb_pipeline.md
Name: mem_wb_pipeline

Overview:
EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core, plus the data-memory access FSM for the MEM stage. The block consumes EX-stage results and produces the mem_rd/mem_regWrite/wb_rd/wb_regWrite signals and forwarding data that feed data_forwarding. It also drives the register-file write port. It generates the pipeline stall for load-use hazards and for multi-cycle data-memory waits.

Parameters:
DATA_WIDTH, 32, datapath width
REG_SIZE, 5, register index width (regName_t)
TIMEOUT_CYCLES, 16, maximum wait cycles per data-memory access (used only with the optional feature)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX stage holds a real instruction
ex_rd  in  REG_SIZE  EX destination register
ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg  in  1 each  EX control bits
ex_alu_result  in  DATA_WIDTH  ALU result / memory address
ex_store_data  in  DATA_WIDTH  store data, already forwarded
id_rs1, id_rs2  in  REG_SIZE  ID-stage source registers, for the load-use check
dmem_req  out  1  data-memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr, dmem_wdata  out  DATA_WIDTH  access address and store data
dmem_ready  in  1  access complete this cycle
dmem_rdata  in  DATA_WIDTH  load data, valid when dmem_ready=1
mem_rd, wb_rd  out  REG_SIZE  to data_forwarding
mem_regWrite, wb_regWrite  out  1  to data_forwarding, gated by stage valid
mem_fwd_data  out  DATA_WIDTH  EX/MEM ALU result, used as the forwarding source
wb_data  out  DATA_WIDTH  MEM/WB writeback value; also drives rf_wdata
rf_we  out  1  register-file write enable
rf_waddr  out  REG_SIZE  register-file write address
rf_wdata  out  DATA_WIDTH  register-file write data
mem_stall  out  1  MEM access waiting; freezes PC, IF/ID, ID/EX
ld_use_stall  out  1  load-use hazard; upstream holds IF/ID and bubbles ID/EX
stall_cycles  out  32  count of cycles with mem_stall=1
dmem_err  out  1  sticky access-timeout flag

Behaviour:
- Reset (async, immediate):
  - All valids = 0; FSM = IDLE; stall_cycles = 0; dmem_err = 0.
  - All rd and data registers = 0.
  - Consequently dmem_req, mem_regWrite, wb_regWrite, rf_we and both stalls = 0 while rst=1.
  - Reset mid-access drops dmem_req immediately; the in-flight instruction is discarded.
- EX/MEM register:
  - When mem_stall=0, captures all ex_* fields and mem_valid <= ex_valid.
  - When mem_stall=1, holds all fields.
  - regWrite is forced to 0 at capture when ex_rd = 0, so x0 is never forwarded or written.
- mem_regWrite = mem_valid & captured regWrite. mem_rd = captured rd.
- mem_access = mem_valid & (memRead | memWrite).
- FSM states:
  - IDLE: dmem_req = mem_access.
    - If dmem_ready=1 in the same cycle, the access completes with zero wait and the FSM stays IDLE.
    - If mem_access=1 and dmem_ready=0, go to WAIT.
  - WAIT: dmem_req = 1; addr, wdata and we stay stable.
    - On dmem_ready=1, go to IDLE.
- dmem_we = captured memWrite. dmem_addr = captured ALU result. dmem_wdata = captured store data.
- mem_stall = mem_access & ~dmem_ready (combinational). It deasserts in the cycle ready arrives.
- MEM/WB register:
  - When mem_stall=1: wb_valid <= 0 (bubble).
  - Otherwise: wb_valid <= mem_valid; wb_rd <= mem_rd; wb_regWrite <= regWrite; wb_data <= memToReg ? dmem_rdata : ALU result.
- wb_regWrite = wb_valid & captured regWrite.
- rf_we = wb_regWrite; rf_waddr = wb_rd; rf_wdata = wb_data.
- Latency: EX to register-file write is 2 cycles with no wait states, plus 1 cycle per wait state.
- ld_use_stall = ex_valid & ex_memRead & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2). It is combinational and independent of mem_stall.
- stall_cycles increments on every clock with mem_stall=1 and saturates at 32'hFFFF_FFFF.
- Stores never write the register file; regWrite=0 on stores is required of the decoder.

Optional Feature:
Macro DMEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with dmem_ready=0:
    - The access is abandoned and the FSM returns to IDLE.
    - mem_stall deasserts that cycle.
    - A load writes 0 to wb_data.
    - dmem_err is set to 1 and holds until reset.
- Not defined: there is no counter; dmem_err is tied to 0; WAIT lasts indefinitely.

Test Plan:
- ALU op, ex_rd=t1, ex_alu_result=32'h1234, ex_regWrite=1 -> next cycle mem_rd=t1 and mem_regWrite=1; the cycle after, rf_we=1, rf_waddr=t1, rf_wdata=32'h1234.
- Load to t2 with dmem_ready low for 3 cycles, rdata=32'hCAFE -> mem_stall high for exactly 3 cycles; EX/MEM held; wb_valid=0 during the stall; stall_cycles=3; then rf_wdata=32'hCAFE.
- Load in EX with ex_rd=t0 and id_rs2=t0 -> ld_use_stall=1 in the same cycle; with ex_rd=x0 -> ld_use_stall=0.
- ALU op with ex_rd=x0 and ex_regWrite=1 -> mem_regWrite=0, wb_regWrite=0, rf_we=0.
- Assert rst during WAIT -> dmem_req, mem_stall and all valids are 0 immediately; the FSM restarts in IDLE.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, dmem_ready stuck at 0 -> stall ends after 16 cycles; dmem_err=1 and stays set; the load writes 0.
